timer_array: RTL and testbench

TIMER_ARRAY -- requirements
Module: timer_array

---
 rtl/timer_array.sv | 203 ++++++++++++++++++++
 tb/tb_timer_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_array.sv
// Array of independent programmable down/up timers behind a word-addressed
// register file. Each channel owns a 16-byte window: CTRL, PRESET, COUNT, STATUS.

// One timer channel: control/preset/pending registers plus a four-state FSM.
module timer_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_we,
    input  logic             preset_we,
    input  logic             status_we,
    input  logic [31:0]      wdata,
    output logic [3:0]       ctrl,
    output logic [CNT_W-1:0] preset,
    output logic [CNT_W-1:0] count,
    output logic             pend,
    output logic             irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } state_e;

    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_FREE   = 2'b10;

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;

    // Only the low bits of wdata matter to a channel; the rest are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Next-state and register-update logic for the channel.
    // NOTE: every _d is given its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = (mode_q == MODE_FREE) ? '0 : preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (mode_q == MODE_FREE) begin
                    count_d = count_q + CNT_W'(1);
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    // A preset of 0 lands here too, so it expires like a preset of 1.
                    count_d = '0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (mode_q == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set from the FSM is applied after W1C so a collision leaves PEND high.
        if (status_we && wdata[0]) pend_d = 1'b0;
        if (state_q == ST_INT)     pend_d = 1'b1;

        // A software CTRL write overrides the FSM's own EN clear in the same cycle.
        if (ctrl_we) {im_d, mode_d, en_d} = wdata[3:0];
        if (preset_we) preset_d = wdata[CNT_W-1:0];
    end

    // Channel state register with asynchronous clear.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    assign ctrl   = {im_q, mode_q, en_q};
    assign preset = preset_q;
    assign count  = count_q;
    assign pend   = pend_q;
    assign irq    = pend_q & im_q;

endmodule

// Top level: address decode, per-channel write strobes and the read mux.
module timer_array #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq,
    output logic            irq_any
);

    typedef enum logic [1:0] {
        REG_CTRL,
        REG_PRESET,
        REG_COUNT,
        REG_STATUS
    } reg_e;

    // The full upper address is the channel index, so out-of-range windows never alias.
    logic [27:0] ch_idx;
    reg_e        reg_off;
    assign ch_idx  = addr[31:4];
    assign reg_off = reg_e'(addr[3:2]);

    // Byte-lane bits are not part of the word address.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    logic [3:0]       ch_ctrl   [N_CH];
    logic [CNT_W-1:0] ch_preset [N_CH];
    logic [CNT_W-1:0] ch_count  [N_CH];
    logic [N_CH-1:0]  ch_pend;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = we && (ch_idx == 28'(i));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ctrl_we  (hit && (reg_off == REG_CTRL)),
            .preset_we(hit && (reg_off == REG_PRESET)),
            .status_we(hit && (reg_off == REG_STATUS)),
            .wdata    (wdata),
            .ctrl     (ch_ctrl[i]),
            .preset   (ch_preset[i]),
            .count    (ch_count[i]),
            .pend     (ch_pend[i]),
            .irq      (irq[i])
        );
    end

    // Combinational read mux; unmapped channel windows read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_idx == 28'(i)) begin
                case (reg_off)
                    REG_CTRL:   rdata = 32'(ch_ctrl[i]);
                    REG_PRESET: rdata = 32'(ch_preset[i]);
                    REG_COUNT:  rdata = 32'(ch_count[i]);
                    REG_STATUS: rdata = 32'(ch_pend[i]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array with N_CH=2, CNT_W=8. Inputs change just after
// a rising edge; outputs are sampled 1-8 ns after that edge (10 ns period).
module tb_timer_array;

    localparam int N_CH  = 2;
    localparam int CNT_W = 8;

    localparam logic [31:0] CTRL0 = 32'h00, PRESET0 = 32'h04, COUNT0 = 32'h08, STATUS0 = 32'h0C;
    localparam logic [31:0] CTRL1 = 32'h10, PRESET1 = 32'h14, COUNT1 = 32'h18, STATUS1 = 32'h1C;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     addr;
    logic            we;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [N_CH-1:0] irq;
    logic            irq_any;

    int total = 0;
    int bad   = 0;

    timer_array #(
        .N_CH (N_CH),
        .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single-cycle register write; the next rising edge is the write edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic [1:0] exp_irq);
        check({tag, "_irq"}, {30'd0, irq}, {30'd0, exp_irq});
        check({tag, "_any"}, {31'd0, irq_any}, {31'd0, |exp_irq});
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // Reset state
        rd("rst_ctrl0", CTRL0, 32'h0);
        rd("rst_count1", COUNT1, 32'h0);
        rd("rst_status0", STATUS0, 32'h0);
        chk_irq("rst", 2'b00);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Register access: COUNT read-only, PRESET truncation, CTRL unused bits
        wr(COUNT0, 32'h55);
        rd("count_ro", COUNT0, 32'h0);
        wr(PRESET0, 32'hFFFF_FFAB);
        rd("preset_trunc", PRESET0, 32'hAB);
        wr(CTRL0, 32'hFFFF_FFF8);
        rd("ctrl_bits", CTRL0, 32'h8);
        tick(3);
        rd("idle_hold", COUNT0, 32'h0);
        wr(CTRL0, 32'h0);

        // One-shot, preset 5: INT reached at edge 7, PEND visible after edge 8
        wr(PRESET0, 32'd5);
        wr(CTRL0, 32'h9);
        tick(3);
        rd("os_count_e3", COUNT0, 32'd4);
        tick(4);
        rd("os_pend_e7", STATUS0, 32'h0);
        rd("os_count_e7", COUNT0, 32'h0);
        chk_irq("os_e7", 2'b00);
        tick(1);
        rd("os_pend_e8", STATUS0, 32'h1);
        chk_irq("os_e8", 2'b01);
        rd("os_ctrl_e8", CTRL0, 32'h8);
        rd("os_count_e8", COUNT0, 32'h0);
        wr(STATUS0, 32'h0);
        rd("w0_noeffect", STATUS0, 32'h1);
        tick(5);
        rd("pend_sticky", STATUS0, 32'h1);
        wr(STATUS0, 32'h1);
        rd("w1c", STATUS0, 32'h0);
        chk_irq("w1c", 2'b00);

        // Auto-reload on channel 1, preset 3: PEND at edges 6, 11, ...
        wr(PRESET1, 32'd3);
        wr(CTRL1, 32'hB);
        tick(5);
        rd("ar_pend_e5", STATUS1, 32'h0);
        tick(1);
        rd("ar_pend_e6", STATUS1, 32'h1);
        chk_irq("ar_e6", 2'b10);
        wr(STATUS1, 32'h1);
        rd("ar_w1c_e7", STATUS1, 32'h0);
        tick(3);
        rd("ar_pend_e10", STATUS1, 32'h0);
        tick(1);
        rd("ar_pend_e11", STATUS1, 32'h1);
        wr(CTRL1, 32'h0);
        tick(4);
        rd("ar_freeze", COUNT1, 32'd3);
        wr(STATUS1, 32'h1);
        rd("ar_clr", STATUS1, 32'h0);

        // PRESET=0 behaves as PRESET=1 (PEND after edge 4), masked irq
        wr(PRESET1, 32'd0);
        wr(CTRL1, 32'h1);
        tick(3);
        rd("p0_pend_e3", STATUS1, 32'h0);
        tick(1);
        rd("p0_pend_e4", STATUS1, 32'h1);
        chk_irq("p0_masked", 2'b00);
        rd("p0_ctrl", CTRL1, 32'h0);
        wr(STATUS1, 32'h1);

        // Masking and W1C colliding with the INT cycle (preset 2, INT at edge 4)
        wr(PRESET0, 32'd2);
        wr(CTRL0, 32'h1);
        tick(4);
        wr(STATUS0, 32'h1);
        rd("coll_pend", STATUS0, 32'h1);
        chk_irq("coll_masked", 2'b00);
        rd("coll_ctrl", CTRL0, 32'h0);
        wr(CTRL0, 32'h8);
        chk_irq("unmask", 2'b01);
        wr(STATUS0, 32'h1);
        rd("coll_clr", STATUS0, 32'h0);
        chk_irq("coll_clr", 2'b00);

        // CTRL write in the INT cycle wins over the FSM's EN clear
        wr(PRESET0, 32'd1);
        wr(CTRL0, 32'h9);
        tick(3);
        wr(CTRL0, 32'hB);
        rd("int_ctrl_wr", CTRL0, 32'hB);
        wr(STATUS0, 32'h1);
        rd("int_wr_clr", STATUS0, 32'h0);
        tick(2);
        rd("int_wr_e7", STATUS0, 32'h0);
        tick(1);
        rd("int_wr_e8", STATUS0, 32'h1);
        wr(CTRL0, 32'h0);
        wr(STATUS0, 32'h1);
        rd("int_wr_stop", STATUS0, 32'h0);
        tick(2);
        rd("int_wr_idle", STATUS0, 32'h0);

        // PRESET write mid-count does not disturb the running count
        wr(PRESET0, 32'd10);
        wr(CTRL0, 32'h9);
        tick(3);
        rd("mid_count_e3", COUNT0, 32'd9);
        wr(PRESET0, 32'd100);
        rd("mid_count_e4", COUNT0, 32'd8);
        tick(8);
        rd("mid_pend_e12", STATUS0, 32'h0);
        tick(1);
        rd("mid_pend_e13", STATUS0, 32'h1);
        rd("mid_preset", PRESET0, 32'd100);
        wr(STATUS0, 32'h1);
        wr(CTRL0, 32'h9);
        tick(2);
        rd("new_preset", COUNT0, 32'd100);
        tick(3);
        rd("run_e5", COUNT0, 32'd97);
        wr(CTRL0, 32'h0);
        tick(5);
        rd("en0_freeze", COUNT0, 32'd96);
        rd("en0_nopend", STATUS0, 32'h0);

        // Free-run, 8-bit: COUNT=k-2 after edge k, wraps 0xFF -> 0x00
        wr(CTRL0, 32'h5);
        tick(257);
        rd("fr_ff", COUNT0, 32'hFF);
        tick(1);
        rd("fr_wrap", COUNT0, 32'h00);
        for (int k = 0; k < 600; k++) begin
            tick(1);
            check("fr_irq", {30'd0, irq}, 32'h0);
        end
        rd("fr_nopend", STATUS0, 32'h0);
        wr(CTRL0, 32'h0);

        // Asynchronous reset between edges while counting
        wr(PRESET1, 32'd50);
        wr(CTRL1, 32'h9);
        wr(PRESET0, 32'd1);
        wr(CTRL0, 32'h9);
        tick(4);
        check("pre_rst_irq", {30'd0, irq}, 32'h1);
        rd("pre_rst_count1", COUNT1, 32'd46);
        #1 reset = 1'b1;
        #1;
        chk_irq("async_rst", 2'b00);
        rd("async_count1", COUNT1, 32'h0);
        rd("async_status0", STATUS0, 32'h0);
        rd("async_ctrl1", CTRL1, 32'h0);
        rd("async_preset1", PRESET1, 32'h0);
        reset = 1'b0;
        tick(5);
        rd("post_rst_count1", COUNT1, 32'h0);
        rd("post_rst_ctrl1", CTRL1, 32'h0);
        rd("post_rst_status1", STATUS1, 32'h0);

        // Unmapped channel windows read zero and ignore writes (no aliasing)
        wr(32'h20, 32'hF);
        wr(32'h24, 32'h55);
        wr(32'h100, 32'hF);
        rd("oor_20", 32'h20, 32'h0);
        rd("oor_24", 32'h24, 32'h0);
        rd("oor_100", 32'h100, 32'h0);
        rd("oor_alias_ctrl0", CTRL0, 32'h0);
        rd("oor_alias_preset0", PRESET0, 32'h0);
        chk_irq("oor", 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
